input_debounce: RTL

INPUT_DEBOUNCE -- requirements
Module: input_debounce

---
 rtl/input_debounce.sv | 120 ++++++++++++
 1 files changed

// File: rtl/input_debounce.sv
// Per-channel pushbutton debouncer: two-flop synchroniser, 1 ms prescaler, stability counters.
// Optional sticky press latch on `events`, built only when INPUT_DEBOUNCE_EVENT_LATCH_EN is defined.
module input_debounce #(
  parameter int unsigned WIDTH            = 4,
  parameter int unsigned sysclk_frequency = 1330,
  parameter int unsigned debounce_ms      = 10,
  parameter bit          invert           = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] pressed,
  output logic [WIDTH-1:0] released,
  input  logic [WIDTH-1:0] event_clr,
  output logic [WIDTH-1:0] events
);

  localparam int unsigned PRESC_TOP = sysclk_frequency * 100 - 1;
  localparam int unsigned PRESC_W   = $clog2(PRESC_TOP + 1);
  localparam int unsigned CNT_W     = 8;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESC_TOP);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(debounce_ms - 1);
  // Raw level of a released button; also what the synchroniser holds in reset.
  localparam logic [WIDTH-1:0]   RAW_IDLE  = {WIDTH{invert}};

  logic [WIDTH-1:0]   sync1_q, sync1_d;
  logic [WIDTH-1:0]   sync2_q, sync2_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0]   cnt_q [WIDTH];
  logic [CNT_W-1:0]   cnt_d [WIDTH];
  logic [WIDTH-1:0]   level_q, level_d;
  logic [WIDTH-1:0]   pressed_q, pressed_d;
  logic [WIDTH-1:0]   released_q, released_d;
  logic [WIDTH-1:0]   sync_in;
  logic               tick;

  // Synchroniser chain and polarity normalisation.
  always_comb begin
    sync1_d = raw_in;
    sync2_d = sync1_q;
    sync_in = sync2_q ^ RAW_IDLE;
  end

  // 1 ms time base.
  always_comb begin
    tick    = (presc_q == PRESC_MAX);
    presc_d = tick ? '0 : presc_q + PRESC_W'(1);
  end

  // Stability counters: any match clears, a mismatch advances once per tick.
  always_comb begin
    cnt_d      = cnt_q;
    level_d    = level_q;
    pressed_d  = '0;
    released_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync_in[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == CNT_LAST) begin
          cnt_d[i]      = '0;
          level_d[i]    = sync_in[i];
          pressed_d[i]  = sync_in[i];
          released_d[i] = ~sync_in[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= RAW_IDLE;
      sync2_q    <= RAW_IDLE;
      presc_q    <= '0;
      cnt_q      <= '{default: '0};
      level_q    <= '0;
      pressed_q  <= '0;
      released_q <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      level_q    <= level_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
    end
  end

  assign level    = level_q;
  assign pressed  = pressed_q;
  assign released = released_q;

`ifdef INPUT_DEBOUNCE_EVENT_LATCH_EN
  logic [WIDTH-1:0] events_q, events_d;

  // Set wins over clear so a press arriving with a clear is never lost.
  always_comb begin
    events_d = (events_q & ~event_clr) | pressed_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      events_q <= '0;
    end else begin
      events_q <= events_d;
    end
  end

  assign events = events_q;
`else
  logic [WIDTH-1:0] unused_event_clr;
  assign unused_event_clr = event_clr;
  assign events           = '0;
`endif

endmodule
